// File: rtl/pit_if.sv
// ---------------------------------------------------------------------------
// pit_if -- bus bundle for the Pending Interest Table (pit).
//
// Groups every non-clock, non-reset signal of pit:
//   interest_valid/prefix/len, interest_ready   : ingress interest handshake
//   fib_out_prefix/len, fib_out_bit             : new interest forwarded to fib
//   pit_in_prefix/len, prefix_ready             : returning data prefix from fib
//   start_send_to_pit, rejected                 : answer to fib (hit / miss)
//   data_in, data_in_valid                      : data bytes from fib
//   data_out, data_out_valid, data_out_last     : data bytes to downstream face
//   entries_used                                : number of valid table entries
//   stat_aggregated/rejected/expired            : event counters, only when
//                                                 PIT_STATS_EN is defined
//
// Modports:
//   slave  -- the pit itself
//   master -- the environment around pit (ingress parser + fib + downstream)
// ---------------------------------------------------------------------------
interface pit_if;
    logic        interest_valid;
    logic [63:0] interest_prefix;
    logic [5:0]  interest_len;
    logic        interest_ready;

    logic [63:0] fib_out_prefix;
    logic [5:0]  fib_out_len;
    logic        fib_out_bit;

    logic [63:0] pit_in_prefix;
    logic [5:0]  pit_in_len;
    logic        prefix_ready;
    logic        start_send_to_pit;
    logic        rejected;

    logic [7:0]  data_in;
    logic        data_in_valid;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        data_out_last;

    logic [6:0]  entries_used;

`ifdef PIT_STATS_EN
    logic [15:0] stat_aggregated;
    logic [15:0] stat_rejected;
    logic [15:0] stat_expired;
`endif

    modport slave (
        input  interest_valid, interest_prefix, interest_len,
        input  pit_in_prefix, pit_in_len, prefix_ready,
        input  data_in, data_in_valid,
        output interest_ready,
        output fib_out_prefix, fib_out_len, fib_out_bit,
        output start_send_to_pit, rejected,
        output data_out, data_out_valid, data_out_last,
`ifdef PIT_STATS_EN
        output stat_aggregated, stat_rejected, stat_expired,
`endif
        output entries_used
    );

    modport master (
        output interest_valid, interest_prefix, interest_len,
        output pit_in_prefix, pit_in_len, prefix_ready,
        output data_in, data_in_valid,
        input  interest_ready,
        input  fib_out_prefix, fib_out_len, fib_out_bit,
        input  start_send_to_pit, rejected,
        input  data_out, data_out_valid, data_out_last,
`ifdef PIT_STATS_EN
        input  stat_aggregated, stat_rejected, stat_expired,
`endif
        input  entries_used
    );
endinterface

// File: rtl/pit.sv
// ---------------------------------------------------------------------------
// pit -- Pending Interest Table between ingress interest parsing and fib.
//
// New interests are recorded in a fully associative table and forwarded to
// fib once; repeats of a pending interest are aggregated. When fib returns a
// data prefix, the table is searched: a hit answers start_send_to_pit, takes
// DATA_BYTES bytes from fib, streams them downstream with one cycle of delay
// and then retires the entry; a miss answers rejected. Unsatisfied entries
// expire TIMEOUT cycles after insertion.
//
// Ports:
//   clk  -- clock, rising edge
//   rst  -- synchronous reset, active-high
//   bus  -- pit_if.slave, all interest / fib / data / status signals
//
// Parameters:
//   DEPTH       number of table entries (2..64)
//   TIMEOUT     lifetime of an unsatisfied entry in cycles (>=4)
//   DATA_BYTES  bytes per accepted data packet
//
// Build option:
//   PIT_STATS_EN  when defined, adds saturating 16-bit counters
//                 stat_aggregated, stat_rejected, stat_expired.
// ---------------------------------------------------------------------------
module pit #(
    parameter int DEPTH      = 16,
    parameter int TIMEOUT    = 4096,
    parameter int DATA_BYTES = 1024
) (
    input  logic clk,
    input  logic rst,
    pit_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int AGE_W = $clog2(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT - 1);
    localparam logic [15:0]      LAST_CNT = 16'(DATA_BYTES - 1);

    typedef enum logic {I_IDLE, I_FWD} i_state_t;
    typedef enum logic [2:0] {D_IDLE, D_LOOK, D_RESP, D_REJ, D_XFER} d_state_t;

    function automatic logic [6:0] count_ones(input logic [DEPTH-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++)
            n = n + {6'd0, v[i]};
        return n;
    endfunction

    // Table storage: valid/busy are control, the rest is payload.
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_busy;
    logic [63:0]      ent_prefix [DEPTH];
    logic [5:0]       ent_len    [DEPTH];
    logic [AGE_W-1:0] ent_age    [DEPTH];

    i_state_t    i_state;
    d_state_t    d_state;

    logic [63:0] look_prefix;
    logic [5:0]  look_len;
    logic [IDX_W-1:0] xfer_idx;
    logic [15:0] xfer_cnt;

    logic        fib_bit_r;
    logic [63:0] fib_prefix_r;
    logic [5:0]  fib_len_r;
    logic        start_r;
    logic        rej_r;
    logic [6:0]  used_r;

    logic [7:0]  data_p1;
    logic        vld_p1;
    logic        last_p1;

    // Associative compares for the ingress interest and the pending lookup.
    logic [DEPTH-1:0] int_match;
    logic [DEPTH-1:0] look_match;
    logic             int_hit;
    logic             free_any;
    logic [IDX_W-1:0] free_idx;
    logic             look_hit;
    logic [IDX_W-1:0] look_idx;

    always_comb begin
        int_match  = '0;
        look_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            int_match[i]  = ent_valid[i] && (ent_prefix[i] == bus.interest_prefix)
                            && (ent_len[i] == bus.interest_len);
            look_match[i] = ent_valid[i] && (ent_prefix[i] == look_prefix)
                            && (ent_len[i] == look_len);
        end
    end

    // Descending scan so the lowest matching / free index is the one kept.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        look_hit = 1'b0;
        look_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (look_match[i]) begin
                look_hit = 1'b1;
                look_idx = IDX_W'(i);
            end
        end
    end

    assign int_hit = |int_match;

    // Aggregation never needs a free slot, so a full table still accepts a
    // repeat of a pending interest.
    logic handshake, do_insert, do_agg, do_hit, do_miss, retire;

    assign bus.interest_ready = (i_state == I_IDLE) && (int_hit || free_any);
    assign handshake = bus.interest_valid && bus.interest_ready;
    assign do_insert = handshake && !int_hit;
    assign do_agg    = handshake && int_hit;
    assign do_hit    = (d_state == D_LOOK) && look_hit;
    assign do_miss   = (d_state == D_LOOK) && !look_hit;
    assign retire    = (d_state == D_XFER) && bus.data_in_valid && (xfer_cnt == LAST_CNT);

    // Next table state. Inserts target a slot that is free now, so they never
    // collide with a hit, an expiry or a retire in the same cycle.
    logic [DEPTH-1:0] valid_n;
    logic [DEPTH-1:0] busy_n;
    logic [DEPTH-1:0] exp_vec;
    logic [AGE_W-1:0] age_n [DEPTH];

    always_comb begin
        valid_n = ent_valid;
        busy_n  = ent_busy;
        exp_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age_n[i] = ent_age[i];
            if (ent_valid[i] && !ent_busy[i]) begin
                if (ent_age[i] == AGE_MAX) begin
                    // A hit in the same cycle claims the entry before it ages out.
                    if (!(do_hit && (look_idx == IDX_W'(i))))
                        exp_vec[i] = 1'b1;
                end else begin
                    age_n[i] = ent_age[i] + 1'b1;
                end
            end
        end
        valid_n = valid_n & ~exp_vec;
        if (do_hit)
            busy_n[look_idx] = 1'b1;
        if (retire) begin
            valid_n[xfer_idx] = 1'b0;
            busy_n[xfer_idx]  = 1'b0;
        end
        if (do_insert) begin
            valid_n[free_idx] = 1'b1;
            busy_n[free_idx]  = 1'b0;
            age_n[free_idx]   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            ent_busy  <= '0;
            used_r    <= '0;
        end else begin
            ent_valid <= valid_n;
            ent_busy  <= busy_n;
            used_r    <= count_ones(valid_n);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++)
            ent_age[i] <= age_n[i];
        if (do_insert) begin
            ent_prefix[free_idx] <= bus.interest_prefix;
            ent_len[free_idx]    <= bus.interest_len;
        end
    end

    // Interest FSM: one forward strobe per inserted interest.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_state      <= I_IDLE;
            fib_bit_r    <= 1'b0;
            fib_prefix_r <= '0;
            fib_len_r    <= '0;
        end else begin
            fib_bit_r <= 1'b0;
            case (i_state)
                I_IDLE: begin
                    if (do_insert) begin
                        i_state      <= I_FWD;
                        fib_bit_r    <= 1'b1;
                        fib_prefix_r <= bus.interest_prefix;
                        fib_len_r    <= bus.interest_len;
                    end
                end
                I_FWD:   i_state <= I_IDLE;
                default: i_state <= I_IDLE;
            endcase
        end
    end

    // Lookup key and claimed entry index are payload; no reset needed.
    always_ff @(posedge clk) begin
        if ((d_state == D_IDLE) && bus.prefix_ready) begin
            look_prefix <= bus.pit_in_prefix;
            look_len    <= bus.pit_in_len;
        end
        if (do_hit)
            xfer_idx <= look_idx;
    end

    // Data FSM with the one-cycle byte pipeline (stage p0 = data_in, p1 = data_out).
    always_ff @(posedge clk) begin
        if (rst) begin
            d_state  <= D_IDLE;
            start_r  <= 1'b0;
            rej_r    <= 1'b0;
            xfer_cnt <= '0;
            data_p1  <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            start_r <= 1'b0;
            rej_r   <= 1'b0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            case (d_state)
                D_IDLE: begin
                    if (bus.prefix_ready)
                        d_state <= D_LOOK;
                end
                D_LOOK: begin
                    if (look_hit) begin
                        start_r <= 1'b1;
                        d_state <= D_RESP;
                    end else begin
                        rej_r   <= 1'b1;
                        d_state <= D_REJ;
                    end
                end
                D_RESP: begin
                    xfer_cnt <= '0;
                    d_state  <= D_XFER;
                end
                D_REJ: d_state <= D_IDLE;
                D_XFER: begin
                    if (bus.data_in_valid) begin
                        // ---- stage p0 -> p1 ----
                        data_p1  <= bus.data_in;
                        vld_p1   <= 1'b1;
                        xfer_cnt <= xfer_cnt + 16'd1;
                        if (xfer_cnt == LAST_CNT) begin
                            last_p1 <= 1'b1;
                            d_state <= D_IDLE;
                        end
                    end
                end
                default: d_state <= D_IDLE;
            endcase
        end
    end

    assign bus.fib_out_bit       = fib_bit_r;
    assign bus.fib_out_prefix    = fib_prefix_r;
    assign bus.fib_out_len       = fib_len_r;
    assign bus.start_send_to_pit = start_r;
    assign bus.rejected          = rej_r;
    assign bus.data_out          = data_p1;
    assign bus.data_out_valid    = vld_p1;
    assign bus.data_out_last     = last_p1;
    assign bus.entries_used      = used_r;

`ifdef PIT_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [6:0] n);
        logic [16:0] s;
        s = {1'b0, v} + {10'd0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0] stat_agg_r;
    logic [15:0] stat_rej_r;
    logic [15:0] stat_exp_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_agg_r <= '0;
            stat_rej_r <= '0;
            stat_exp_r <= '0;
        end else begin
            if (do_agg)
                stat_agg_r <= sat_inc(stat_agg_r, 7'd1);
            if (do_miss)
                stat_rej_r <= sat_inc(stat_rej_r, 7'd1);
            // Several entries can age out in the same cycle.
            stat_exp_r <= sat_inc(stat_exp_r, count_ones(exp_vec));
        end
    end

    assign bus.stat_aggregated = stat_agg_r;
    assign bus.stat_rejected   = stat_rej_r;
    assign bus.stat_expired    = stat_exp_r;
`else
    logic unused_agg;
    assign unused_agg = do_agg ^ do_miss;
`endif
endmodule
